// File: rtl/equiv_mon_pkg.sv
// Shared types and helpers for the equivalence mismatch monitor.
// Record layout, state encoding and saturating increment.
package equiv_mon_pkg;

  localparam int WIDTH = 91;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_WARMUP,
    S_RUN,
    S_FROZEN
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] cycle;
    logic [WIDTH-1:0] diff;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/equiv_rec_fifo.sv
// Synchronous first-word-fall-through FIFO of mismatch records.
// Head reads as zero when empty; push into a full FIFO succeeds only with a pop.
module equiv_rec_fifo
  import equiv_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  rec_t din,
  output logic valid,
  output logic full,
  output rec_t dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [AW:0]   cnt;
  rec_t          mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign valid   = cnt != '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // When full with a pop, wr == rd: the head is read before this write lands.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/equiv_mismatch_monitor.sv
// Compares two instance outputs after a warm-up window, counts mismatches
// and queues {cycle, diff} records for a valid/ready consumer.
module equiv_mismatch_monitor
  import equiv_mon_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int WARMUP        = 2,
  parameter bit STOP_ON_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_cycle,
  output logic [WIDTH-1:0] rec_diff,
  output logic             armed,
  output logic             mismatch_any,
  output logic [CNT_W-1:0] first_cycle,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             overflow
);

  localparam int     WW   = $clog2(WARMUP + 2);
  localparam state_t INIT = (WARMUP == 0) ? S_RUN : S_WARMUP;

  state_t        state;
  logic [WW-1:0] warm;
  logic          miss;
  logic          pop;
  logic          full;
  rec_t          rec_in;
  rec_t          head;

  assign miss   = en & (state == S_RUN) & (y_1 != y_2);
  assign pop    = rec_valid & rec_ready;
  assign rec_in = '{cycle: cycle_count, diff: y_1 ^ y_2};
  assign armed  = state == S_RUN;

  assign rec_cycle = head.cycle;
  assign rec_diff  = head.diff;

  equiv_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (miss & ~clr),
    .pop   (pop),
    .din   (rec_in),
    .valid (rec_valid),
    .full  (full),
    .dout  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= INIT;
      warm           <= '0;
      mismatch_any   <= 1'b0;
      first_cycle    <= '0;
      mismatch_count <= '0;
      cycle_count    <= '0;
      overflow       <= 1'b0;
    end else if (clr) begin
      state          <= INIT;
      warm           <= '0;
      mismatch_any   <= 1'b0;
      first_cycle    <= '0;
      mismatch_count <= '0;
      cycle_count    <= '0;
      overflow       <= 1'b0;
    end else if (en) begin
      unique case (state)
        S_WARMUP: begin
          if (warm == WW'(WARMUP - 1)) begin
            state <= S_RUN;
            warm  <= '0;
          end else begin
            warm <= warm + 1'b1;
          end
        end
        S_RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (y_1 != y_2) begin
            mismatch_count <= sat_inc(mismatch_count);
            mismatch_any   <= 1'b1;
            if (!mismatch_any) first_cycle <= cycle_count;
            if (full & ~pop)   overflow    <= 1'b1;
            if (STOP_ON_FIRST) state       <= S_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
